// File: rtl/prog_loader_pkg.sv
// Shared constants and loader state type for the UART program loader.
// The CSUM state only exists when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;
    localparam int STOP_BITS      = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } load_state_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, half-bit start validation,
// mid-bit sampling; emits a 1-cycle byte_valid or frame_err per frame.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 frame_err
);

    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int FRAME_BITS = DATA_BITS + STOP_BITS;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;

    rx_state_t            rx_state;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]     tmr;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            tmr        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    tmr     <= '0;
                    bit_cnt <= '0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    // a line already back high at mid-start is a glitch
                    if (tmr == CNT_W'(CLKS_PER_BIT/2 - 1)) begin
                        tmr      <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (tmr == CNT_W'(CLKS_PER_BIT - 1)) begin
                        tmr     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                            rx_state <= RX_IDLE;
                            if (rx_sync) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shreg;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else if (bit_cnt < 4'(DATA_BITS)) begin
                            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: length-prefixed byte stream -> 32-bit instruction writes.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              uart_rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset
);

    localparam int LEN_W = 8 * LEN_BYTES;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    typedef logic [LEN_W:0] lenx_t;
    localparam lenx_t MAX_LEN = lenx_t'(2**ADDR_W);

    logic                 byte_valid, frame_err;
    logic [DATA_BITS-1:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    load_state_t      state;
    logic [LEN_W-1:0] len, len_next;
    logic [ADDR_W:0]  word_cnt;
    logic [IDX_W-1:0] byte_idx;
    logic [23:0]      word_sh;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign len_next = {len[LEN_W-9:0], byte_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b0;
            len       <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_sh   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            // busy is high exactly in the receiving states
            if (busy && frame_err) begin
                state     <= ST_ERROR;
                busy      <= 1'b0;
                err       <= 1'b1;
                cpu_reset <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start) begin
                            state     <= ST_LEN_HI;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            cpu_reset <= 1'b0;
                            word_cnt  <= '0;
                            byte_idx  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum      <= '0;
`endif
                        end else begin
                            cpu_reset <= (state != ST_ERROR);
                        end
                    end
                    ST_LEN_HI: begin
                        if (byte_valid) begin
                            len   <= len_next;
                            state <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (byte_valid) begin
                            len <= len_next;
                            if (len_next == '0) begin
                                state     <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                cpu_reset <= 1'b1;
                            end else if (lenx_t'(len_next) > MAX_LEN) begin
                                state <= ST_ERROR;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            csum <= csum ^ byte_data;
`endif
                            word_sh  <= {word_sh[15:0], byte_data};
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                                wr_en    <= 1'b1;
                                wr_addr  <= word_cnt[ADDR_W-1:0];
                                wr_data  <= {word_sh, byte_data};
                                word_cnt <= word_cnt + 1'b1;
                                if (lenx_t'(word_cnt) + lenx_t'(1) == lenx_t'(len)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                    state <= ST_CSUM;
`else
                                    state     <= ST_DONE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    cpu_reset <= 1'b1;
`endif
                                end
                            end
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (byte_valid) begin
                            busy <= 1'b0;
                            if (byte_data == csum) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                cpu_reset <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed sessions plus randomized loads.
module tb_prog_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          uart_rx = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy, done, err, cpu_reset;

    prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .uart_rx   (uart_rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] u8_t;
    typedef u8_t bytes_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    wr_t mon_e;
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %08h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL write: got addr %0h data %08h expected addr %0h data %08h",
                             wr_addr, wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input u8_t b, input bit stop_ok);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 uart_rx = stop_ok;
        repeat (CPB) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("err_cleared", err, 0);
        chk("cpu_reset_held", cpu_reset, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(posedge clk);
        #1 chk("session_ends", busy, 0);
    endtask

    // One load session. data may be shorter than 4*len when bad_tail ends it.
    task automatic session(input logic [15:0] len, input bytes_t data,
                           input bit corrupt_csum, input bit bad_tail, input bit glitch);
        bit    exp_ok;
        bit    any_wr;
        u8_t   x;
        logic [31:0] last_word;
        wr_t   e;
        x = 8'h00;
        any_wr = 1'b0;
        last_word = '0;
        pulse_start();
        send_byte(len[15:8], 1'b1);
        send_byte(len[7:0], 1'b1);
        if (glitch) begin
            @(posedge clk); #1 uart_rx = 1'b0;
            @(posedge clk); #1 uart_rx = 1'b1;
            repeat (3 * CPB) @(posedge clk);
        end
        if (len == 0) begin
            exp_ok = 1'b1;
        end else if (len > 16) begin
            exp_ok = 1'b0;
        end else begin
            for (int w = 0; w < int'(len) && 4*w + 3 < data.size(); w++) begin
                e.addr = w[AW-1:0];
                e.data = {data[4*w], data[4*w+1], data[4*w+2], data[4*w+3]};
                exp_q.push_back(e);
                last_word = e.data;
                any_wr = 1'b1;
            end
            foreach (data[i]) begin
                x ^= data[i];
                send_byte(data[i], 1'b1);
            end
            if (bad_tail) begin
                send_byte(8'h00, 1'b0);
                exp_ok = 1'b0;
            end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                send_byte(corrupt_csum ? (x ^ 8'h01) : x, 1'b1);
                exp_ok = !corrupt_csum;
`else
                exp_ok = 1'b1;
`endif
            end
        end
        wait_idle();
        chk("done", done, exp_ok);
        chk("err", err, !exp_ok);
        chk("cpu_reset", cpu_reset, exp_ok);
        chk("writes_outstanding", exp_q.size(), 0);
        if (any_wr) chk("wr_data_hold", wr_data, last_word);
        exp_q.delete();
    endtask

    initial begin
        bytes_t d;
        int     len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cpu_reset", cpu_reset, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 chk("cpu_reset_idle", cpu_reset, 1);

        d = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        session(16'd2, d, 1'b0, 1'b0, 1'b0);
        d = {};
        session(16'd0, d, 1'b0, 1'b0, 1'b0);
        session(16'd17, d, 1'b0, 1'b0, 1'b0);
        d = {8'hAA};
        session(16'd1, d, 1'b0, 1'b1, 1'b0);
        d = {8'h01, 8'h02, 8'h03, 8'h04};
        session(16'd1, d, 1'b0, 1'b0, 1'b1);
        session(16'd1, d, 1'b1, 1'b0, 1'b0);

        // reset mid-word: no write may appear, everything returns to reset values
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_cpu_reset", cpu_reset, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("abort_cpu_reset_release", cpu_reset, 1);
        d = {8'hCA, 8'hFE, 8'hBA, 8'hBE};
        session(16'd1, d, 1'b0, 1'b0, 1'b0);

        // randomized sessions, including over-length and truncated-by-frame-error
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(0, 18);
            d = {};
            if (len >= 1 && len <= 16) begin
                for (int i = 0; i < 4*len; i++) d.push_back(8'($urandom));
            end
            if (len >= 1 && len <= 16 && $urandom_range(0, 4) == 0) begin
                int keep;
                keep = $urandom_range(0, 4*len - 1);
                while (d.size() > keep) void'(d.pop_back());
                session(16'(len), d, 1'b0, 1'b1, 1'b0);
            end else begin
                session(16'(len), d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
